vga_timing_gen: RTL

//  Raster timing source feeding the colour-mapping stage: generates DrawX/DrawY scan position,

---
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source: scan counters, sync/blank decode and a pixel-aligned
// output pipeline that registers the mapper colour and blanks it outside the visible area.
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DEPTH = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  Red,
  input  logic [7:0]  Green,
  input  logic [7:0]  Blue,
  output logic        pixel_ce,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef struct packed {
    logic        hs_n;
    logic        vs_n;
    logic        blank_n;
    logic [23:0] rgb;
  } pix_t;

  localparam pix_t PIX_RST = '{hs_n: 1'b1, vs_n: 1'b1, blank_n: 1'b0, rgb: 24'h0};

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       hc, vc, hc_nx, vc_nx;
  logic             hs_raw, vs_raw, act;
  pix_t             stage_in;
  pix_t             pipe [PIPE_DEPTH];

  // pixel_ce is registered so it reads 0 in reset and first rises CLK_DIV clocks after release.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt  <= '0;
      pixel_ce <= 1'b0;
    end else begin
      pixel_ce <= (div_cnt == DIV_W'(CLK_DIV - 1));
      div_cnt  <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    hc_nx = hc + 10'd1;
    vc_nx = vc;
    if (hc == 10'(H_TOTAL - 1)) begin
      hc_nx = 10'd0;
      vc_nx = (vc == 10'(V_TOTAL - 1)) ? 10'd0 : vc + 10'd1;
    end
  end

  // Signed int compares keep degenerate (zero-width) timing regions well defined.
  assign hs_raw = !((int'(hc) >= HS_START) && (int'(hc) < HS_END));
  assign vs_raw = !((int'(vc) >= VS_START) && (int'(vc) < VS_END));
  assign act    = (int'(hc) < H_VISIBLE) && (int'(vc) < V_VISIBLE);

  always_comb begin
    stage_in         = PIX_RST;
    stage_in.hs_n    = hs_raw;
    stage_in.vs_n    = vs_raw;
    stage_in.blank_n = act;
    stage_in.rgb     = act ? {Red, Green, Blue} : 24'h0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hc          <= 10'd0;
      vc          <= 10'd0;
      frame_tick  <= 1'b0;
      frame_count <= 16'd0;
      for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= PIX_RST;
    end else begin
      frame_tick <= 1'b0;
      if (pixel_ce) begin
        hc      <= hc_nx;
        vc      <= vc_nx;
        pipe[0] <= stage_in;
        for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
        // Frame boundary: the enable that moves the raster onto the first blanking line.
        if (hc_nx == 10'd0 && vc_nx == 10'(V_VISIBLE)) begin
          frame_tick  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign VGA_HS      = pipe[PIPE_DEPTH-1].hs_n;
  assign VGA_VS      = pipe[PIPE_DEPTH-1].vs_n;
  assign VGA_BLANK_N = pipe[PIPE_DEPTH-1].blank_n;
  assign VGA_R       = pipe[PIPE_DEPTH-1].rgb[23:16];
  assign VGA_G       = pipe[PIPE_DEPTH-1].rgb[15:8];
  assign VGA_B       = pipe[PIPE_DEPTH-1].rgb[7:0];

endmodule
